// File: rtl/ascon_ctrl_pkg.sv
// Shared types and block-split helpers for the ASCON-128 phase controller.
// Contents: state_t (controller phases), ctrl_t (registered output bundle),
// RATE_BYTES, nblocks() and blk_len().
package ascon_ctrl_pkg;

  localparam int unsigned RATE_BYTES = 8;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned RND_W      = 4;

  typedef enum logic [3:0] {
    IDLE,
    INIT_P,
    INIT_W,
    KEY1,
    AD_REQ,
    AD_P,
    AD_W,
    DSEP,
    MSG_REQ,
    MSG_P,
    MSG_W,
    KEY2,
    FIN_P,
    FIN_W,
    TAG
  } state_t;

  // Registered control outputs, kept together so they share one register.
  typedef struct packed {
    logic             perm_start;
    logic [RND_W-1:0] perm_rounds;
    logic             block_req;
    logic             msg_sel;
    logic [LEN_W-1:0] datalen;
    logic             key_xor_en;
    logic             key_sel;
    logic             domain_sep;
    logic             tag_valid;
    logic             busy;
  } ctrl_t;

  // Number of rate blocks for a byte count: AD may be empty, the message
  // always has at least one (possibly empty, padding-only) block.
  function automatic logic [CNT_W-1:0] nblocks(input logic [LEN_W-1:0] len,
                                               input logic             is_msg);
    if (!is_msg && (len == LEN_W'(0)))
      nblocks = CNT_W'(0);
    else if (len < LEN_W'(RATE_BYTES))
      nblocks = CNT_W'(1);
    else
      nblocks = CNT_W'(2);
  endfunction

  // Valid bytes in block idx: first block is full when len >= 8, the
  // second carries the remainder, which may be zero.
  function automatic logic [LEN_W-1:0] blk_len(input logic [LEN_W-1:0] len,
                                               input logic [CNT_W-1:0] idx);
    if (idx == CNT_W'(0))
      blk_len = (len >= LEN_W'(RATE_BYTES)) ? LEN_W'(RATE_BYTES) : len;
    else if (idx == CNT_W'(1))
      blk_len = len - LEN_W'(RATE_BYTES);
    else
      blk_len = LEN_W'(0);
  endfunction

endpackage

// File: rtl/ascon_sequencer.sv
// Top-level phase controller for the ASCON-128 AEAD core.
// Sequences init, AD absorption, domain separation, message processing,
// finalization and tag release; drives the permutation core and the
// rate/key XOR enables, and fetches rate blocks from the loaders.
// Ports:
//   clk, nRST            clock, asynchronous active-low reset
//   start, decrypt       begin an operation / mode (sampled in IDLE)
//   AD_len, PT_len       AD and message byte counts 0..15 (sampled in IDLE)
//   abort                synchronous return to IDLE
//   perm_done            permutation finished pulse
//   block_valid          loader presents the requested block
//   perm_start           permutation kick
//   perm_rounds          round count for the current permutation
//   block_req, msg_sel   block request / loader select (1 = message)
//   absorb_en            XOR block into rate (block_req & block_valid)
//   datalen              valid bytes in the current block
//   key_xor_en, key_sel  key XOR enable / position (1 = capacity head)
//   domain_sep           XOR 1 into the state LSB
//   tag_valid            tag on the state bus, marks completion
//   busy                 operation in progress
module ascon_sequencer
  import ascon_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 6
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       start,
  input  logic       decrypt,
  input  logic [3:0] AD_len,
  input  logic [3:0] PT_len,
  input  logic       abort,
  input  logic       perm_done,
  input  logic       block_valid,
  output logic       perm_start,
  output logic [3:0] perm_rounds,
  output logic       block_req,
  output logic       msg_sel,
  output logic       absorb_en,
  output logic [3:0] datalen,
  output logic       key_xor_en,
  output logic       key_sel,
  output logic       domain_sep,
  output logic       tag_valid,
  output logic       busy
);

  state_t           state_q, state_d;
  logic             decrypt_q, decrypt_d;
  logic [LEN_W-1:0] ad_len_q, ad_len_d;
  logic [LEN_W-1:0] pt_len_q, pt_len_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  ctrl_t            ctrl_q, ctrl_d;

  // Mode is held for the datapath only; no control output depends on it.
  logic unused_decrypt;
  assign unused_decrypt = decrypt_q;

  // State, latched operation parameters and output register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      decrypt_q <= 1'b0;
      ad_len_q  <= '0;
      pt_len_q  <= '0;
      blk_cnt_q <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      decrypt_q <= decrypt_d;
      ad_len_q  <= ad_len_d;
      pt_len_q  <= pt_len_d;
      blk_cnt_q <= blk_cnt_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Next-state, block counter and parameter latch; abort overrides all.
  always_comb begin
    state_d   = state_q;
    decrypt_d = decrypt_q;
    ad_len_d  = ad_len_q;
    pt_len_d  = pt_len_q;
    blk_cnt_d = blk_cnt_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            decrypt_d = decrypt;
            ad_len_d  = AD_len;
            pt_len_d  = PT_len;
            blk_cnt_d = '0;
            state_d   = INIT_P;
          end
        end
        INIT_P: state_d = INIT_W;
        INIT_W: if (perm_done) state_d = KEY1;
        KEY1:   state_d = (ad_len_q != LEN_W'(0)) ? AD_REQ : DSEP;
        AD_REQ: begin
          if (block_valid) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
            state_d   = AD_P;
          end
        end
        AD_P: state_d = AD_W;
        AD_W: begin
          if (perm_done)
            state_d = (blk_cnt_q < nblocks(ad_len_q, 1'b0)) ? AD_REQ : DSEP;
        end
        DSEP: begin
          blk_cnt_d = '0;
          state_d   = MSG_REQ;
        end
        MSG_REQ: begin
          // The last message block goes straight to finalization unpermuted.
          if (block_valid) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
            state_d   = ((blk_cnt_q + CNT_W'(1)) < nblocks(pt_len_q, 1'b1))
                        ? MSG_P : KEY2;
          end
        end
        MSG_P: state_d = MSG_W;
        MSG_W: if (perm_done) state_d = MSG_REQ;
        KEY2:  state_d = FIN_P;
        FIN_P: state_d = FIN_W;
        FIN_W: if (perm_done) state_d = TAG;
        TAG:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore decode of the upcoming state so the outputs come straight from flops.
  always_comb begin
    ctrl_d = '0;
    ctrl_d.busy = (state_d != IDLE);
    unique case (state_d)
      INIT_P, FIN_P: begin
        ctrl_d.perm_start  = 1'b1;
        ctrl_d.perm_rounds = RND_W'(ROUNDS_A);
      end
      INIT_W, FIN_W: ctrl_d.perm_rounds = RND_W'(ROUNDS_A);
      AD_P, MSG_P: begin
        ctrl_d.perm_start  = 1'b1;
        ctrl_d.perm_rounds = RND_W'(ROUNDS_B);
      end
      AD_W, MSG_W: ctrl_d.perm_rounds = RND_W'(ROUNDS_B);
      KEY1: ctrl_d.key_xor_en = 1'b1;
      KEY2: begin
        ctrl_d.key_xor_en = 1'b1;
        ctrl_d.key_sel    = 1'b1;
      end
      AD_REQ: begin
        ctrl_d.block_req = 1'b1;
        ctrl_d.datalen   = blk_len(ad_len_d, blk_cnt_d);
      end
      MSG_REQ: begin
        ctrl_d.block_req = 1'b1;
        ctrl_d.msg_sel   = 1'b1;
        ctrl_d.datalen   = blk_len(pt_len_d, blk_cnt_d);
      end
      DSEP: ctrl_d.domain_sep = 1'b1;
      TAG:  ctrl_d.tag_valid  = 1'b1;
      default: ;
    endcase
  end

  assign perm_start  = ctrl_q.perm_start;
  assign perm_rounds = ctrl_q.perm_rounds;
  assign block_req   = ctrl_q.block_req;
  assign msg_sel     = ctrl_q.msg_sel;
  assign datalen     = ctrl_q.datalen;
  assign key_xor_en  = ctrl_q.key_xor_en;
  assign key_sel     = ctrl_q.key_sel;
  assign domain_sep  = ctrl_q.domain_sep;
  assign tag_valid   = ctrl_q.tag_valid;
  assign busy        = ctrl_q.busy;

  // Absorb in the cycle the loader answers the request.
  assign absorb_en   = ctrl_q.block_req & block_valid;

endmodule

// File: tb/tb_ascon_sequencer.sv
// Self-checking bench for ascon_sequencer: responds as permutation core and
// block loaders, records the observable event stream of each operation and
// compares it with a transaction-level model built from the byte counts.
module tb_ascon_sequencer;

  logic       clk = 1'b0;
  logic       nRST;
  logic       start, decrypt, abort, perm_done, block_valid;
  logic [3:0] AD_len, PT_len;
  logic       perm_start, block_req, msg_sel, absorb_en;
  logic [3:0] perm_rounds, datalen;
  logic       key_xor_en, key_sel, domain_sep, tag_valid, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int pend     = 0;
  int reqcnt   = 0;

  ascon_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clk(clk), .nRST(nRST), .start(start), .decrypt(decrypt),
    .AD_len(AD_len), .PT_len(PT_len), .abort(abort),
    .perm_done(perm_done), .block_valid(block_valid),
    .perm_start(perm_start), .perm_rounds(perm_rounds),
    .block_req(block_req), .msg_sel(msg_sel), .absorb_en(absorb_en),
    .datalen(datalen), .key_xor_en(key_xor_en), .key_sel(key_sel),
    .domain_sep(domain_sep), .tag_valid(tag_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input integer got, input integer exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, integer'({perm_start, perm_rounds, block_req, msg_sel, absorb_en,
                       datalen, key_xor_en, key_sel, domain_sep, tag_valid,
                       busy}), 0);
  endtask

  // One cycle of permutation-core and loader behaviour (at the negedge).
  // Permutation finishes d cycles after its kick; loader answers after v
  // cycles of request.
  task automatic resp_cycle(input int d, input int v);
    perm_done   = 1'b0;
    block_valid = 1'b0;
    if (perm_start === 1'b1) begin
      pend = d;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) perm_done = 1'b1;
    end
    if (block_req === 1'b1) begin
      if (reqcnt == v) begin
        block_valid = 1'b1;
        reqcnt = 0;
      end else begin
        reqcnt++;
      end
    end
  endtask

  task automatic start_op(input int dec, input int ad, input int pt);
    @(negedge clk);
    start = 1'b1; decrypt = dec[0]; AD_len = 4'(ad); PT_len = 4'(pt);
    @(negedge clk);
    start = 1'b0;
    pend = 0; reqcnt = 0;
  endtask

  // Full operation; events encoded as 100+rounds (permutation), 200+len (AD
  // absorb), 300+len (message absorb), 400+key_sel, 500 dsep, 600 tag.
  task automatic run_op(input int dec, input int ad, input int pt,
                        input int d, input int v, input bit spur);
    int exp_q[$];
    int got_q[$];
    int adl[$];
    int ml[$];
    int exp_tag, tag_cyc, cyc;
    bit done, prev_req;
    logic [3:0] prev_len;
    if (ad > 0) begin
      if (ad < 8) adl.push_back(ad);
      else begin adl.push_back(8); adl.push_back(ad - 8); end
    end
    if (pt < 8) ml.push_back(pt);
    else begin ml.push_back(8); ml.push_back(pt - 8); end
    exp_q.push_back(112);
    exp_q.push_back(400);
    foreach (adl[i]) begin
      exp_q.push_back(200 + adl[i]);
      exp_q.push_back(106);
    end
    exp_q.push_back(500);
    foreach (ml[i]) begin
      exp_q.push_back(300 + ml[i]);
      if (i < ml.size() - 1) exp_q.push_back(106);
    end
    exp_q.push_back(401);
    exp_q.push_back(112);
    exp_q.push_back(600);
    exp_tag = 3 + d + adl.size() * (v + 2 + d) + 1
              + (ml.size() - 1) * (v + 2 + d) + (v + 1) + 2 + d;

    start_op(dec, ad, pt);
    cyc = 1; done = 0; tag_cyc = -1; prev_req = 0; prev_len = '0;
    while (!done && cyc < 700) begin
      start = 1'b0;
      if (busy !== 1'b1) chk("busy_during_op", busy, 1);
      resp_cycle(d, v);
      if (spur) begin
        if (block_req === 1'b1 && msg_sel === 1'b0) begin
          perm_done = 1'b1;
          start = 1'b1;
          decrypt = ~decrypt;
          AD_len = 4'($urandom);
          PT_len = 4'($urandom);
        end else if (block_req !== 1'b1) begin
          block_valid = 1'b1;
        end
      end
      if (block_req === 1'b1 && prev_req) begin
        chk("req_datalen_stable", datalen, prev_len);
        chk("no_perm_in_req", perm_start, 0);
      end
      prev_req = (block_req === 1'b1);
      prev_len = datalen;
      #1;
      if (perm_start === 1'b1) got_q.push_back(100 + perm_rounds);
      if (absorb_en === 1'b1) got_q.push_back((msg_sel ? 300 : 200) + datalen);
      if (key_xor_en === 1'b1) got_q.push_back(400 + key_sel);
      if (domain_sep === 1'b1) got_q.push_back(500);
      if (tag_valid === 1'b1) begin
        got_q.push_back(600);
        tag_cyc = cyc;
        done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    perm_done = 1'b0; block_valid = 1'b0; start = 1'b0;
    chk("tag_seen", done, 1);
    chk("tag_cycle", tag_cyc, exp_tag);
    chk("event_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) chk("event", got_q[i], exp_q[i]);
    end
    chk("idle_after_tag", busy, 0);
    chk("tag_one_cycle", tag_valid, 0);
  endtask

  initial begin
    bit seen;
    int n12;
    nRST = 1'b0; start = 1'b0; decrypt = 1'b0; AD_len = '0; PT_len = '0;
    abort = 1'b0; perm_done = 1'b0; block_valid = 1'b0;
    #1;
    chk_zero("reset_outs");
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    chk_zero("idle_outs");

    // start together with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);
    start = 1'b0; abort = 1'b0;

    // best case, then the directed scenarios
    run_op(0, 0, 3, 1, 0, 0);
    run_op(0, 8, 15, 5, 0, 0);
    run_op(1, 5, 0, 1, 0, 0);
    run_op(0, 0, 10, 2, 20, 0);
    run_op(0, 10, 12, 3, 3, 1);

    // abort while waiting on an AD permutation
    start_op(0, 5, 3);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (seen) break;
      seen = (perm_start === 1'b1 && perm_rounds == 4'd6);
      resp_cycle(5, 0);
      @(negedge clk);
    end
    chk("reach_ad_w", seen, 1);
    perm_done = 1'b0; block_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    chk_zero("abort_outs");
    abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_tag", {busy, tag_valid}, 0);
    end
    run_op(0, 5, 3, 1, 0, 0);

    // reset while waiting on the finalization permutation
    start_op(1, 3, 9);
    seen = 0; n12 = 0;
    for (int c = 0; c < 120; c++) begin
      if (seen) break;
      if (perm_start === 1'b1 && perm_rounds == 4'd12) n12++;
      seen = (n12 == 2);
      resp_cycle(5, 1);
      @(negedge clk);
    end
    chk("reach_fin_w", seen, 1);
    perm_done = 1'b0; block_valid = 1'b0;
    nRST = 1'b0;
    #1;
    chk_zero("nrst_outs");
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    chk_zero("after_nrst_outs");
    run_op(1, 3, 9, 1, 0, 0);

    // randomized operations
    for (int k = 0; k < 10; k++)
      run_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(1, 6)),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_sequencer.md
# ascon_sequencer

Top-level phase controller for the ASCON-128 AEAD core. It sequences initialization, associated-data absorption, domain separation, message processing, finalization and tag release. It drives the permutation core's start/round controls and the rate-XOR/key-XOR enables. It requests 8-byte rate blocks from the AD and message loaders over a request/valid handshake.

## Interface
Parameters:
- ROUNDS_A, 12: rounds for the initialization and finalization permutations
- ROUNDS_B, 6: rounds for the intermediate (AD and message) permutations

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- start  in  1  begin one AEAD operation; honoured only in IDLE
- decrypt  in  1  mode, sampled with start
- AD_len  in  4  AD byte count 0..15, sampled with start
- PT_len  in  4  message byte count 0..15, sampled with start
- abort  in  1  synchronous return to IDLE
- perm_done  in  1  one-cycle pulse from the permutation core
- block_valid  in  1  loader has the requested block this cycle
- perm_start  out  1  one-cycle permutation kick
- perm_rounds  out  4  round count for the current permutation
- block_req  out  1  request the next rate block
- msg_sel  out  1  0 = AD loader, 1 = message loader
- absorb_en  out  1  XOR block into rate (ciphertext overwrite when decrypt_q)
- datalen  out  4  valid bytes in the current block, 0..8
- key_xor_en  out  1  XOR key into the state
- key_sel  out  1  0 = key into capacity tail (post-init), 1 = key into capacity head (pre-final)
- domain_sep  out  1  XOR 1 into the state LSB
- tag_valid  out  1  tag on the state bus; doubles as done
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, INIT_P, INIT_W, KEY1, AD_REQ, AD_P, AD_W, DSEP, MSG_REQ, MSG_P, MSG_W, KEY2, FIN_P, FIN_W, TAG.
- Sampling: IDLE & start latches decrypt_q, ad_len_q, pt_len_q, clears blk_cnt (2 bit) and moves to INIT_P.
- *_P states: one cycle, perm_start=1, next *_W. perm_rounds = ROUNDS_A in INIT/FIN states, ROUNDS_B in AD/MSG states, 0 elsewhere.
- *_W states wait for perm_done.
  - INIT_W goes to KEY1.
  - AD_W goes to AD_REQ or DSEP.
  - MSG_W goes to MSG_REQ.
  - FIN_W goes to TAG.
- KEY1: key_xor_en=1, key_sel=0. Next: AD_REQ if ad_len_q≠0, else DSEP.
- AD block count:
  - 0 if len=0.
  - 1 if 1..7.
  - 2 if 8..15; first block full, second padded with datalen=len−8, which may be 0.
- Message block count: 1 if 0..7, 2 if 8..15. Same datalen rule as AD; a lone block has datalen=len.
- AD_REQ/MSG_REQ hold block_req=1 and datalen. msg_sel=1 in MSG_REQ.
- On block_valid, absorb_en=1 in that same cycle, blk_cnt increments, then:
  - AD_REQ goes to AD_P. AD_W then goes to AD_REQ if more blocks remain, else DSEP.
  - MSG_REQ goes to MSG_P if not the last block, else KEY2. The last message block is never permuted.
- DSEP: domain_sep=1, blk_cnt cleared, next MSG_REQ.
- KEY2: key_xor_en=1, key_sel=1, next FIN_P.
- TAG: tag_valid=1 for one cycle, next IDLE.

## Timing
- Reset: state IDLE; all outputs 0; latched lengths and blk_cnt cleared.
- Outputs are Moore decodes of state, blk_cnt and the latched lengths. No combinational path from any input to an output, except absorb_en, which is block_req & block_valid.
- perm_done and block_valid may arrive on the first cycle of their wait state; there is no minimum wait.
- Best-case latency: start accepted at cycle 0 with AD_len=0, PT_len≤7, and perm_done/block_valid immediate gives tag_valid at cycle 9.
- Each extra AD or message block adds 3 cycles, plus permutation latency.
- start while busy: ignored, and the latched values do not change.
- perm_done outside *_W and block_valid outside *_REQ: ignored.
- abort in any state: IDLE next cycle, no tag_valid. abort takes priority over every other transition.
- start and abort together in IDLE: stay in IDLE.
- nRST low mid-operation: immediately IDLE with all outputs 0.

## Structure
- Package ascon_ctrl_pkg holds:
  - state_t enum;
  - RATE_BYTES=8;
  - function nblocks(len, is_msg) returning 0..2;
  - function blk_len(len, idx) returning 0..8.
- No sub-module: a single FSM plus a 2-bit block counter.

## Test plan
- AD_len=0, PT_len=3, immediate handshakes:
  - perm_start at cycles 1 (rounds 12) and 7 (rounds 12);
  - one message block with datalen=3;
  - no AD_REQ;
  - tag_valid at cycle 9.
- AD_len=8, PT_len=15, 5-cycle permutation latency:
  - AD blocks have datalen 8 then 0;
  - message blocks have datalen 8 then 7;
  - perm_rounds sequence 12,6,6,6,12;
  - domain_sep exactly once, between the last AD_W and the first MSG_REQ.
- AD_len=5, PT_len=0, decrypt=1:
  - AD datalen=5;
  - message block datalen=0, absorbed with no permutation before KEY2;
  - key_sel 0 then 1.
- block_valid withheld for 20 cycles in MSG_REQ: block_req and datalen held stable; no perm_start.
- Spurious perm_done in AD_REQ and a second start while busy: no state change, and the latched lengths stay unchanged.
- abort in AD_W, and separately nRST low in FIN_W: IDLE on the next cycle (immediately for nRST), all outputs 0, no tag_valid. A fresh start then completes normally.
